// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and the read-tag type for the RAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_arb_pkg;

    localparam int RAM_AW = 9;
    localparam int RAM_DW = 8;
    localparam int CNT_W  = 16;
    localparam int RD_LAT = 2;
    // Requester index width; covers the largest legal NREQ of 8.
    localparam int IDX_W  = 3;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side bundle for the RAM port arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready per requester; responses and the RAM side have none.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RAM_AW,
    parameter int DW   = RAM_DW
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*DW-1:0]    req_wdata;
    logic [NREQ-1:0]       rsp_valid;
    logic [DW-1:0]         rsp_rdata;
    logic [AW-1:0]         ram_addr;
    logic [DW-1:0]         ram_wdata;
    logic                  ram_we;
    logic [DW-1:0]         ram_q;
    logic [NREQ*CNT_W-1:0] grant_cnt;

    // Requesters plus the RAM model: drive requests and RAM read data.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_q,
        input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_we, grant_cnt
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_q,
        output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_we, grant_cnt
    );

endinterface

// File: rtl/ram_port_arbiter_rr.sv
// Round-robin pick: first set request at or above the pointer, wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: none; the grant depends only on the request vector and the pointer.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Walk the requests in priority order starting at the pointer; the first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            automatic int w_cand = int'(i_ptr) + k;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            // Constant indices only: compare every slot against the candidate.
            for (int j = 0; j < NREQ; j++) begin
                if (!o_any && (j == w_cand) && i_req[j]) begin
                    o_any      = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port between NREQ requesters, round-robin; optional grant stats (RAM_ARB_STATS_EN).
// Latency: request to registered RAM command 1 cycle; read accept to rsp_valid exactly 2 cycles.
// Backpressure: at most one req_ready per cycle; responses cannot be stalled.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RAM_AW,
    parameter int DW   = RAM_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_port_arbiter_if.slave bus
);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("ram_port_arbiter: NREQ must be in 2..8");
        end
    endgenerate

    logic [IDX_W-1:0] r_ptr;
    logic [NREQ-1:0]  w_grant;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_wdata;
    logic             w_sel_we;
    logic [AW-1:0]    r_ram_addr;
    logic [DW-1:0]    r_ram_wdata;
    logic             r_ram_we;
    rd_tag_t          r_tag [RD_LAT];
    logic [NREQ-1:0]  w_rsp_valid;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign bus.req_ready = w_grant;

    // One-hot mux of the winner's command fields.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr  = bus.req_addr[i*AW +: AW];
                w_sel_wdata = bus.req_wdata[i*DW +: DW];
                w_sel_we    = bus.req_we[i];
            end
        end
    end

    // Pointer moves to the slot just past the winner; idle cycles leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_idx == IDX_W'(NREQ - 1)) ? '0 : w_idx + IDX_W'(1);
        end
    end

    // Issue stage: register the granted command; address/data hold when idle so the RAM sees no glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
        end else if (w_any) begin
            r_ram_addr  <= w_sel_addr;
            r_ram_wdata <= w_sel_wdata;
            r_ram_we    <= w_sel_we;
        end else begin
            r_ram_we    <= 1'b0;
        end
    end

    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.ram_we    = r_ram_we;

    // Read tags travel alongside the command; the last stage lines up with the RAM output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= '{vld: w_any & ~w_sel_we, id: w_idx};
            for (int k = 1; k < RD_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Decode the returning tag to a one-hot response strobe; data is the raw RAM output.
    always_comb begin
        w_rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_tag[RD_LAT-1].vld && (r_tag[RD_LAT-1].id == IDX_W'(i))) begin
                w_rsp_valid[i] = 1'b1;
            end
        end
    end

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = bus.ram_q;

`ifdef RAM_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt [NREQ];

    // Saturating per-requester grant counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Flatten the counters onto the stats port.
    always_comb begin
        bus.grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end
`else
    assign bus.grant_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboarded bench for ram_port_arbiter with a behavioural RAM and reference model.
// Latency: expects rsp two cycles after a read accept.
// Backpressure: requesters hold their request until accepted, occasionally withdrawing.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 9;
    localparam int DW   = 8;
    localparam int MEMN = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] init_val(input int k);
        if (k == 32'h1A5) return 8'h3C;
        return DW'(k * 13 + 5);
    endfunction

    // Behavioural synchronous RAM, reloaded with a known pattern while in reset.
    logic [DW-1:0] ram_mem [MEMN];
    logic [DW-1:0] ram_q_r;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < MEMN; k++) ram_mem[k] <= init_val(k);
        end else if (bus.ram_we) begin
            ram_mem[bus.ram_addr] <= bus.ram_wdata;
        end
        ram_q_r <= ram_mem[bus.ram_addr];
    end
    assign bus.ram_q = ram_q_r;

    // Reference model state.
    logic [DW-1:0] mdl_mem [MEMN];
    int            mdl_p;
    int            mdl_cnt [NREQ];
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin rule: scan upward from the pointer, wrapping.
    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(mdl_p + k) % NREQ]) return (mdl_p + k) % NREQ;
        end
        return -1;
    endfunction

    // Monitor: every cycle, the response bus must match the scoreboard head (or be idle).
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                rsp_t e;
                e = sb_q.pop_front();
                check("rsp_valid", 64'(bus.rsp_valid), 64'(1 << e.id));
                check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.data));
            end else begin
                check("rsp_idle", 64'(bus.rsp_valid), 64'(0));
            end
        end
    end

    // One request cycle: called at posedge+1, returns at the next posedge+1.
    task automatic drive_cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] we,
                               input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d,
                               output int winner);
        logic [AW-1:0] wa;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        check("ram_we", 64'(bus.ram_we), 64'(exp_we));
        check("ram_addr", 64'(bus.ram_addr), 64'(exp_addr));
        check("ram_wdata", 64'(bus.ram_wdata), 64'(exp_wd));
        winner = pick(v);
        check("req_ready", 64'(bus.req_ready), (winner >= 0) ? 64'(1 << winner) : 64'(0));
        if (winner >= 0) begin
            wa       = a[winner*AW +: AW];
            mdl_p    = (winner + 1) % NREQ;
            exp_addr = wa;
            exp_wd   = d[winner*DW +: DW];
            exp_we   = we[winner];
            mdl_cnt[winner]++;
            if (we[winner]) mdl_mem[wa] = d[winner*DW +: DW];
            else sb_q.push_back('{due: cyc + 2, id: winner, data: mdl_mem[wa]});
        end else begin
            exp_we = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        int w;
        repeat (n) drive_cycle('0, '0, '0, '0, w);
    endtask

    task automatic check_stats;
`ifdef RAM_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            check("grant_cnt", 64'(bus.grant_cnt[i*16 +: 16]),
                  64'((mdl_cnt[i] > 65535) ? 65535 : mdl_cnt[i]));
`else
        check("grant_cnt_tied", 64'(bus.grant_cnt), 64'(0));
`endif
    endtask

    task automatic do_reset(input int n);
        bus.req_valid = '0;
        rst_n = 1'b0;
        sb_q.delete();
        mdl_p = 0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
        for (int k = 0; k < MEMN; k++) mdl_mem[k] = init_val(k);
        for (int i = 0; i < NREQ; i++) mdl_cnt[i] = 0;
        repeat (n) begin
            @(negedge clk);
            check("rst_ram_we", 64'(bus.ram_we), 64'(0));
            check("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
            check("rst_ram_wdata", 64'(bus.ram_wdata), 64'(0));
            check("rst_grant_cnt", 64'(bus.grant_cnt), 64'(0));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
        logic [NREQ-1:0]    v, we, last_rdy;
        int                 w;
        int                 order3 [8];
        int                 order4 [4];
        order3 = '{0, 1, 2, 3, 0, 1, 2, 3};
        order4 = '{3, 1, 3, 1};
        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;

        do_reset(2);

        // Single read by requester 2 of the preloaded location.
        a = '0; a[2*AW +: AW] = 9'h1A5;
        drive_cycle(4'b0100, '0, a, '0, w);
        check("t1_winner", 64'(bus.req_ready === 4'b0100), 64'(1));
        idle(3);

        // Write then read of the same address by requester 0.
        a = '0; a[0 +: AW] = 9'h010; d = '0; d[0 +: DW] = 8'hA5;
        drive_cycle(4'b0001, 4'b0001, a, d, w);
        drive_cycle(4'b0001, 4'b0000, a, d, w);
        idle(3);

        // Full load from p=0.
        do_reset(1);
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NREQ; i++) a[i*AW +: AW] = AW'(16 * i + c);
            drive_cycle(4'b1111, '0, a, '0, w);
            check("t3_order", 64'(w), 64'(order3[c]));
        end
        idle(3);
`ifdef RAM_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            check("t3_grant_cnt", 64'(bus.grant_cnt[i*16 +: 16]), 64'(2));
`endif

        // Requesters 1 and 3 only, after moving the pointer to 2.
        a = '0; a[1*AW +: AW] = 9'h1A5;
        drive_cycle(4'b0010, '0, a, '0, w);
        for (int c = 0; c < 4; c++) begin
            a = '0; a[1*AW +: AW] = AW'(40 + c); a[3*AW +: AW] = AW'(60 + c);
            drive_cycle(4'b1010, '0, a, '0, w);
            check("t4_order", 64'(w), 64'(order4[c]));
        end
        idle(3);

        // Reset one cycle after a read accept: the read must vanish.
        a = '0; a[2*AW +: AW] = 9'h1A5;
        drive_cycle(4'b0100, '0, a, '0, w);
        do_reset(2);
        idle(4);
        drive_cycle(4'b1111, '0, '0, '0, w);
        check("t5_ptr0", 64'(w), 64'(0));
        idle(3);

        // Random traffic with hold-until-ready behaviour.
        v = '0; we = '0; a = '0; d = '0; last_rdy = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] || last_rdy[i]) begin
                    v[i]              = ($urandom_range(0, 3) != 0);
                    we[i]             = ($urandom_range(0, 2) == 0);
                    a[i*AW +: AW]     = AW'($urandom_range(0, 15));
                    d[i*DW +: DW]     = DW'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    v[i] = 1'b0;
                end
            end
            drive_cycle(v, we, a, d, w);
            last_rdy = (w >= 0) ? NREQ'(1 << w) : '0;
        end
        idle(3);
        check_stats();

`ifdef RAM_ARB_STATS_EN
        // Saturation of requester 0's counter.
        do_reset(1);
        a = '0; a[0 +: AW] = 9'h0F0; d = '0; d[0 +: DW] = 8'h5A;
        for (int c = 0; c < 65540; c++) drive_cycle(4'b0001, 4'b0001, a, d, w);
        idle(2);
        check("sat_cnt0", 64'(bus.grant_cnt[15:0]), 64'(16'hFFFF));
        check_stats();
`endif

        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one port of the 512x8 dual-port block RAM between NREQ requesters (e.g. SDRAM read-back path, host config path, DMA engine).
- Accepts at most one request per cycle via valid/ready and drives registered address, data and write-enable to the RAM port.
- Tracks in-flight reads and steers the RAM output back to the requester that issued each read.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 9, RAM address width
- DW, 8, RAM data width

Ports:
- clk  in  1  single clock; RAM port clock is tied to the same net
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  flattened addresses; requester i at bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  flattened write data
- rsp_valid  out  NREQ  read-data valid, one-hot or zero
- rsp_rdata  out  DW  read data, shared by all requesters
- ram_addr  out  AW  to RAM port address
- ram_wdata  out  DW  to RAM port data
- ram_we  out  1  to RAM port write enable
- ram_q  in  DW  from RAM port registered output
- grant_cnt  out  NREQ*16  per-requester grant counters; only populated under RAM_ARB_STATS_EN

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: ram_addr=0, ram_wdata=0, ram_we=0, rsp_valid=0, rr pointer=0, tag pipeline cleared, grant_cnt=0.
- Arbitration (combinational within cycle T):
  - Search req_valid starting at rr pointer p, upward modulo NREQ; the first set bit i wins.
  - req_ready[i]=1 for the winner only. req_ready depends only on req_valid and p, never on the winner's own ready.
  - Handshake completes when req_valid[i]&&req_ready[i].
- Pointer update: on a grant to i, p <= (i+1) mod NREQ. With no valid request, p holds.
- Issue stage, at the clock edge ending T:
  - On a grant: ram_addr <= req_addr[i], ram_wdata <= req_wdata[i], ram_we <= req_we[i].
  - With no grant: ram_we <= 0; ram_addr and ram_wdata hold.
- Read tag pipeline:
  - Stage 1 stores {is_read, id} with the issue. Stage 2 shifts it one cycle later, aligned to the RAM output register.
  - Read accepted in cycle T: rsp_valid[id]=1 in cycle T+2, with rsp_rdata=ram_q (combinational passthrough). Fixed latency 2, no backpressure on responses.
- Writes generate no response.
- Same address, write in T then read in T+1: the read returns the new data. A read and a write can never hit the RAM in the same cycle on this port.
- Throughput: one request per cycle sustained. Under full load each requester is granted once every NREQ cycles (starvation-free).
- Requester-side rule: requesters hold req_* stable while valid and not ready. The arbiter tolerates withdrawal of valid (no state is kept per pending request).
- Reset mid-operation: in-flight reads are discarded; no rsp_valid after rst_n rises until a new read is accepted.
- An out-of-range NREQ is a parameter error (elaboration-time assertion).

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined: one 16-bit counter per requester, incremented on each completed handshake. Counters saturate at 16'hFFFF and are cleared only by reset. Exposed on grant_cnt, counter i at [i*16 +: 16].
- Undefined: the grant_cnt port is still present and tied to 0; no counter flops are inferred.

Decomposition:
- Package ram_arb_pkg:
  - Constants: RAM_AW=9, RAM_DW=8, CNT_W=16, RD_LAT=2.
  - Typedef: rd_tag_t {logic vld; logic [2:0] id}.
- Sub-module rr_arbiter: NREQ-wide request vector plus pointer in, one-hot grant and encoded index out; purely combinational.
- The pointer register, issue stage and tag pipeline stay in ram_port_arbiter.

Test Plan:
- Reset, then single read by req 2 of addr 9'h1A5 (preloaded 8'h3C): req_ready[2] in the same cycle, ram_addr=9'h1A5 one cycle later, rsp_valid=4'b0100 with rsp_rdata=8'h3C two cycles after accept.
- Req 0 writes 8'hA5 to 9'h010, next cycle req 0 reads 9'h010: one grant per cycle, read returns 8'hA5; no rsp_valid for the write.
- All four requesters valid continuously for 8 cycles from p=0: grant order 0,1,2,3,0,1,2,3. With RAM_ARB_STATS_EN, each grant_cnt = 2.
- Only req 1 and req 3 valid, starting at p=2: grants 3,1,3,1. Read responses carry the matching ids at +2 cycles.
- rst_n asserted one cycle after a read is accepted: rsp_valid stays 0 through recovery, ram_we=0, p=0.
- With RAM_ARB_STATS_EN, force req 0 through 65540 grants: grant_cnt[15:0] saturates at 16'hFFFF.
